deference_controller: RTL

//  Half-duplex CSMA/CD transmit scheduler for the reconciliation sublayer (MII, 4 bits/clk).

---
 rtl/deference_controller_pkg.sv | 42 ++++
 rtl/deference_controller_backoff_lfsr.sv | 36 +++
 rtl/deference_controller.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/deference_controller_pkg.sv
// Shared definitions for the half-duplex CSMA/CD deference controller.
//   state_e       : FSM state encoding
//   timing consts : MII clock counts for IPG, jam and backoff slot
//   LFSR consts   : backoff LFSR seed and feedback taps
//   lfsr_step     : one Fibonacci LFSR shift
//   backoff_mask  : low-k-bit mask used to draw the backoff slot count
package deference_controller_pkg;

  typedef enum logic [2:0] {
    StCarrier,
    StIpg1,
    StIpg2,
    StReady,
    StXmit,
    StJam,
    StBackoff
  } state_e;

  // MII runs 4 bits per clock.
  localparam int unsigned IpgCycles    = 24;   // 96 bit times
  localparam int unsigned Ipg1Cycles   = 16;   // first 2/3 of the gap
  localparam int unsigned JamCycles    = 8;    // 32 bit times
  localparam int unsigned SlotCycles   = 128;  // 512 bit times
  localparam int unsigned AttemptLimit = 16;
  localparam int unsigned BackoffLimit = 10;

  localparam logic [15:0] LfsrSeed = 16'hACE1;
  // x^16 + x^14 + x^13 + x^11 + 1 as bit positions 15, 13, 12, 10.
  localparam logic [15:0] LfsrTaps = 16'hB400;

  function automatic logic [15:0] lfsr_step(logic [15:0] cur);
    return {cur[14:0], ^(cur & LfsrTaps)};
  endfunction

  function automatic logic [15:0] backoff_mask(logic [4:0] k);
    if (k >= 5'd16) begin
      return 16'hFFFF;
    end
    return (16'd1 << k) - 16'd1;
  endfunction

endpackage

// File: rtl/deference_controller_backoff_lfsr.sv
// Free-running 16-bit Fibonacci LFSR supplying backoff randomness.
// Ports:
//   clk   : clock, posedge
//   reset : synchronous active-high, loads SEED
//   value : current LFSR contents
module deference_controller_backoff_lfsr
  import deference_controller_pkg::*;
#(
  parameter logic [15:0] SEED = LfsrSeed
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] value
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_step(lfsr_q);
    // The all-zero state is a lock-up; only reachable with a zero seed.
    if (lfsr_d == 16'h0000) begin
      lfsr_d = 16'h0001;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign value = lfsr_q;

endmodule

// File: rtl/deference_controller.sv
// Half-duplex CSMA/CD transmit scheduler (MII, 4 bits per clock).
// Defers to carrier, enforces the inter-packet gap, grants the MAC transmit
// path, and sequences jam, truncated binary exponential backoff and abort.
// Ports:
//   clk       : clock, posedge
//   reset     : synchronous active-high
//   crs       : carrier sense
//   col       : collision detect (only honoured while transmitting)
//   tx_req    : MAC frame pending, held until tx_ok / tx_abort
//   tx_done   : one-cycle pulse, MAC finished the frame
//   tx_grant  : MAC may transmit
//   jam       : drive jam pattern
//   deferring : high unless ready or transmitting
//   tx_ok     : one-cycle pulse, frame sent cleanly
//   tx_abort  : one-cycle pulse, attempt limit reached
//   attempts  : collisions suffered by the current frame
module deference_controller
  import deference_controller_pkg::*;
#(
  parameter int unsigned IPG_CYCLES    = IpgCycles,
  parameter int unsigned IPG1_CYCLES   = Ipg1Cycles,
  parameter int unsigned JAM_CYCLES    = JamCycles,
  parameter int unsigned SLOT_CYCLES   = SlotCycles,
  parameter int unsigned ATTEMPT_LIMIT = AttemptLimit,
  parameter int unsigned BACKOFF_LIMIT = BackoffLimit,
  parameter logic [15:0] LFSR_SEED     = LfsrSeed
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       crs,
  input  logic       col,
  input  logic       tx_req,
  input  logic       tx_done,
  output logic       tx_grant,
  output logic       jam,
  output logic       deferring,
  output logic       tx_ok,
  output logic       tx_abort,
  output logic [4:0] attempts
);

  localparam int unsigned GapW = $clog2(IPG_CYCLES + 1);
  localparam int unsigned JamW = $clog2(JAM_CYCLES + 1);
  // Largest load is (2^BACKOFF_LIMIT - 1) * SLOT_CYCLES; one spare bit.
  localparam int unsigned BoW  = BACKOFF_LIMIT + $clog2(SLOT_CYCLES) + 1;

  state_e          state_q, state_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic [JamW-1:0] jam_cnt_q, jam_cnt_d;
  logic [BoW-1:0]  bo_q, bo_d;
  logic [4:0]      att_q, att_d;
  logic            ok_d, abort_d;
  logic            grant_q, jam_q, deferring_q, ok_q, abort_q;

  logic [15:0]     lfsr_val;
  logic [4:0]      backoff_exp;
  logic [BoW-1:0]  backoff_load;

  deference_controller_backoff_lfsr #(
    .SEED (LFSR_SEED)
  ) u_backoff_lfsr (
    .clk   (clk),
    .reset (reset),
    .value (lfsr_val)
  );

  // Backoff draw: r uniform in [0, 2^k), k = min(attempts, BACKOFF_LIMIT).
  always_comb begin
    backoff_exp  = (att_q > 5'(BACKOFF_LIMIT)) ? 5'(BACKOFF_LIMIT) : att_q;
    backoff_load = BoW'(lfsr_val & backoff_mask(backoff_exp)) * BoW'(SLOT_CYCLES);
  end

  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    jam_cnt_d = jam_cnt_q;
    bo_d      = bo_q;
    att_d     = att_q;
    ok_d      = 1'b0;
    abort_d   = 1'b0;

    unique case (state_q)
      StCarrier: begin
        // The edge that first sees the line idle counts as gap clock 1.
        if (!crs) begin
          state_d = StIpg1;
          gap_d   = GapW'(1);
        end
      end

      StIpg1: begin
        if (crs) begin
          state_d = StCarrier;
        end else begin
          gap_d = gap_q + GapW'(1);
          if (gap_q == GapW'(IPG1_CYCLES - 1)) begin
            state_d = StIpg2;
          end
        end
      end

      // Carrier is deliberately ignored in the last third of the gap.
      StIpg2: begin
        gap_d = gap_q + GapW'(1);
        if (gap_q == GapW'(IPG_CYCLES - 1)) begin
          state_d = tx_req ? StXmit : StReady;
        end
      end

      StReady: begin
        if (tx_req) begin
          state_d = StXmit;
        end else if (crs) begin
          state_d = StCarrier;
        end
      end

      StXmit: begin
        // A finished frame beats a late collision in the same cycle.
        if (tx_done) begin
          state_d = StIpg1;
          gap_d   = GapW'(1);
          ok_d    = 1'b1;
          att_d   = '0;
        end else if (col) begin
          state_d   = StJam;
          jam_cnt_d = '0;
          if (att_q < 5'(ATTEMPT_LIMIT)) begin
            att_d = att_q + 5'd1;
          end
        end
      end

      StJam: begin
        if (jam_cnt_q == JamW'(JAM_CYCLES - 1)) begin
          if (att_q == 5'(ATTEMPT_LIMIT)) begin
            state_d = StCarrier;
            abort_d = 1'b1;
            att_d   = '0;
          end else begin
            state_d = StBackoff;
            bo_d    = backoff_load;
          end
        end else begin
          jam_cnt_d = jam_cnt_q + JamW'(1);
        end
      end

      // A zero draw still spends one clock here before deferral resumes.
      StBackoff: begin
        if (bo_q == '0) begin
          state_d = StCarrier;
        end else begin
          bo_d = bo_q - BoW'(1);
        end
      end

      default: begin
        state_d = StCarrier;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StCarrier;
      gap_q       <= '0;
      jam_cnt_q   <= '0;
      bo_q        <= '0;
      att_q       <= '0;
      grant_q     <= 1'b0;
      jam_q       <= 1'b0;
      deferring_q <= 1'b1;
      ok_q        <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      jam_cnt_q   <= jam_cnt_d;
      bo_q        <= bo_d;
      att_q       <= att_d;
      grant_q     <= (state_d == StXmit);
      jam_q       <= (state_d == StJam);
      deferring_q <= !((state_d == StReady) || (state_d == StXmit));
      ok_q        <= ok_d;
      abort_q     <= abort_d;
    end
  end

  assign tx_grant  = grant_q;
  assign jam       = jam_q;
  assign deferring = deferring_q;
  assign tx_ok     = ok_q;
  assign tx_abort  = abort_q;
  assign attempts  = att_q;

  // Transmit is only ever entered with a pending request.
  a_xmit_needs_req : assert property (@(posedge clk) disable iff (reset)
    ((state_q != StXmit) && (state_d == StXmit)) |-> tx_req);

  a_ok_abort_excl : assert property (@(posedge clk) disable iff (reset)
    !(tx_ok && tx_abort));

endmodule
